pipe_stage_reg: RTL and testbench

Parametrised, handshaked pipeline stage register that replaces the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block. It moves an opaque WIDTH-bit payload between stages using valid/ready handshakes. It supports flush (squash) and optionally a 2-entry skid buffer, so that `in_ready` is fully registered and carries no combinational path from `out_ready`. It also exports occupancy and a saturating back-pressure counter for performance debug.

---
 rtl/pipe_pkg.sv | 15 +
 rtl/pipe_sat_counter.sv | 26 ++
 rtl/pipe_stage_reg.sv | 125 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types for the handshaked pipeline stage register
//
// Purpose: state encoding and occupancy width shared by pipe_stage_reg.
// State values equal the number of held entries so occupancy is the state itself.
package pipe_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [OCC_W-1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_sat_counter.sv
// rtl/pipe_sat_counter.sv - saturating up-counter with enable
//
// Purpose: counts enabled cycles, holds at all-ones, clears on reset.
// Ports:
//   clk    - clock
//   reset  - synchronous active-low reset
//   en     - increment enable
//   count  - current count
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - reusable valid/ready pipeline stage register
//
// Purpose: moves an opaque WIDTH-bit payload between pipeline stages with
// flush support and an optional 2-entry skid buffer (registered in_ready).
// Ports:
//   clk, reset           - clock, synchronous active-low reset
//   flush                - squash held entries and drop the current input beat
//   in_valid/in_ready/in_data    - upstream handshake and payload
//   out_valid/out_ready/out_data - downstream handshake and payload
//   occupancy            - held entries (0..2)
//   stall_cnt            - saturating count of back-pressured cycles
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  pipe_state_e      state_q;
  logic [WIDTH-1:0] main_q;
  logic             out_fire;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign out_fire  = out_valid && out_ready;

  if (SKID != 0) begin : g_skid
    pipe_state_e      state_d;
    logic [WIDTH-1:0] skid_q;
    logic             in_ready_q;
    logic             in_fire;

    assign in_ready = in_ready_q;
    assign in_fire  = in_valid && in_ready_q && !flush;

    always_comb begin
      state_d = state_q;
      if (flush) begin
        state_d = EMPTY;
      end else begin
        case (state_q)
          EMPTY: if (in_fire) state_d = ONE;
          ONE: begin
            if (in_fire && !out_fire)      state_d = TWO;
            else if (!in_fire && out_fire) state_d = EMPTY;
          end
          // in_ready is low in TWO, so only a drain can happen here.
          TWO: if (out_fire) state_d = ONE;
          default: state_d = EMPTY;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        state_q    <= EMPTY;
        main_q     <= '0;
        skid_q     <= '0;
        in_ready_q <= 1'b0;
      end else begin
        state_q    <= state_d;
        // Registered ready: decided from next state, no path from out_ready.
        in_ready_q <= (state_d != TWO);
        // Flush clears only the valid state; payload registers are left alone.
        if (!flush) begin
          if (in_fire && ((state_q == EMPTY) || out_fire)) begin
            main_q <= in_data;
          end else if ((state_q == TWO) && out_fire) begin
            main_q <= skid_q;
          end
          if (in_fire && (state_q == ONE) && !out_fire) begin
            skid_q <= in_data;
          end
        end
      end
    end
  end else begin : g_single
    logic rst_done_q;
    logic in_fire;

    // rst_done_q keeps in_ready low during reset and for the release edge.
    assign in_ready = rst_done_q && (!out_valid || out_ready);
    assign in_fire  = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
      if (!reset) begin
        state_q    <= EMPTY;
        main_q     <= '0;
        rst_done_q <= 1'b0;
      end else begin
        rst_done_q <= 1'b1;
        if (flush) begin
          state_q <= EMPTY;
        end else if (in_fire) begin
          state_q <= ONE;
          main_q  <= in_data;
        end else if (out_fire) begin
          state_q <= EMPTY;
        end
      end
    end
  end

  pipe_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (out_valid && !out_ready),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset;

  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_data, out_data;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;

  logic        flush0, in_valid0, in_ready0, out_valid0, out_ready0;
  logic [7:0]  in_data0, out_data0;
  logic [1:0]  occupancy0;
  logic [1:0]  stall_cnt0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(8), .SKID(1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.WIDTH(8), .SKID(0), .CNT_W(2)) dut0 (
    .clk(clk), .reset(reset), .flush(flush0),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .occupancy(occupancy0), .stall_cnt(stall_cnt0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b0;
    flush0 = 1'b0; in_valid0 = 1'b0; in_data0 = 8'h00; out_ready0 = 1'b0;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_occ", occupancy, 0);
      chk("rst_stall", stall_cnt, 0);
      chk("rst_in_ready0", in_ready0, 0);
    end
    reset = 1'b1; in_valid = 1'b0;
    tick();
    chk("rel_in_ready", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);
    chk("rel_in_ready0", in_ready0, 1);

    // Streaming at full rate
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = 8'(i);
      tick();
      chk("str_out_valid", out_valid, 1);
      chk("str_out_data", out_data, 32'(i));
      chk("str_occ", occupancy, 1);
      chk("str_in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    tick();
    chk("str_drain_valid", out_valid, 0);
    chk("str_drain_occ", occupancy, 0);

    // Skid absorption and ordering
    in_valid = 1'b1; in_data = 8'h10; out_ready = 1'b1;
    tick();
    chk("sk_d10", out_data, 8'h10);
    out_ready = 1'b0; in_data = 8'h11;
    tick();
    chk("sk_occ2", occupancy, 2);
    chk("sk_rdy0", in_ready, 0);
    chk("sk_hold10", out_data, 8'h10);
    chk("sk_stall1", stall_cnt, 1);
    in_data = 8'h12;
    tick();
    chk("sk_occ2b", occupancy, 2);
    chk("sk_hold10b", out_data, 8'h10);
    chk("sk_stall2", stall_cnt, 2);
    out_ready = 1'b1;
    tick();
    chk("sk_d11", out_data, 8'h11);
    chk("sk_rdy1", in_ready, 1);
    chk("sk_occ1", occupancy, 1);
    tick();
    chk("sk_d12", out_data, 8'h12);
    in_valid = 1'b0;
    tick();
    chk("sk_empty", out_valid, 0);

    // Flush in TWO drops the presented beat
    in_valid = 1'b1; in_data = 8'h20; out_ready = 1'b0;
    tick();
    in_data = 8'h21;
    tick();
    chk("fl_occ2", occupancy, 2);
    chk("fl_stall3", stall_cnt, 3);
    flush = 1'b1; in_data = 8'h33;
    tick();
    chk("fl_valid", out_valid, 0);
    chk("fl_occ", occupancy, 0);
    chk("fl_rdy", in_ready, 1);
    chk("fl_stall4", stall_cnt, 4);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("fl_no33_valid", out_valid, 0);
    chk("fl_data_kept", out_data, 8'h20);

    // Reset mid-transfer discards the held entry
    in_valid = 1'b1; in_data = 8'h55;
    tick();
    chk("mr_loaded", out_data, 8'h55);
    reset = 1'b0; in_valid = 1'b0;
    tick();
    chk("mr_valid", out_valid, 0);
    chk("mr_data", out_data, 0);
    chk("mr_stall", stall_cnt, 0);
    chk("mr_rdy", in_ready, 0);
    reset = 1'b1;
    tick();
    chk("mr_rel_rdy", in_ready, 1);

    // Stall counting with stable data
    in_valid = 1'b1; in_data = 8'h44; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("st_data", out_data, 8'h44);
      chk("st_cnt", stall_cnt, 32'(k));
    end
    out_ready = 1'b1;
    tick();
    chk("st_drain", out_valid, 0);
    chk("st_cnt_final", stall_cnt, 5);

    // SKID=0 instance: streaming, combinational ready, saturating counter
    out_ready0 = 1'b1; in_valid0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data0 = 8'h81 + 8'(i);
      #1;
      chk("s0_rdy", in_ready0, 1);
      tick();
      chk("s0_data", out_data0, 32'h81 + 32'(i));
      chk("s0_occ", occupancy0, 1);
    end
    in_valid0 = 1'b0;
    tick();
    chk("s0_empty", out_valid0, 0);
    in_valid0 = 1'b1; in_data0 = 8'h90;
    tick();
    out_ready0 = 1'b0; in_data0 = 8'h91;
    #1;
    chk("s0_rdy_low", in_ready0, 0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("s0_sat", stall_cnt0, (k > 3) ? 32'd3 : 32'(k));
      chk("s0_hold", out_data0, 8'h90);
    end
    out_ready0 = 1'b1;
    #1;
    chk("s0_rdy_comb", in_ready0, 1);
    tick();
    chk("s0_d91", out_data0, 8'h91);
    in_valid0 = 1'b0;
    tick();
    chk("s0_drain", out_valid0, 0);
    chk("s0_sat_hold", stall_cnt0, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
